// File: rtl/atpg_response_checker.sv
// ATPG response checker: compares DUT responses with a golden ROM.
// Ports: clk/rst, start, resp_valid/resp_ready/resp_data, exp_addr/exp_data,
//   busy, done, pass, fail_count, first_fail_{idx,valid,diff}, signature.
// Optional macro RESP_CHECKER_MISR_EN adds a MISR over accepted responses.
module atpg_response_checker #(
  parameter int          OUT_W     = 32,
  parameter int          NUM_VEC   = 10,
  parameter int          IDX_W     = 4,
  parameter logic [31:0] MISR_POLY = 32'h04C11DB7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [OUT_W-1:0] resp_data,
  output logic [IDX_W-1:0] exp_addr,
  input  logic [OUT_W-1:0] exp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W:0]   fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             first_fail_valid,
  output logic [OUT_W-1:0] first_fail_diff,
  output logic [OUT_W-1:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_VEC - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W:0]   FC_ONE  = (IDX_W + 1)'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   fc_q, fc_d;
  logic [IDX_W-1:0] ffi_q, ffi_d;
  logic             ffv_q, ffv_d;
  logic [OUT_W-1:0] ffd_q, ffd_d;

  logic start_acc;
  logic hs;
  logic [OUT_W-1:0] diff;

  assign start_acc = start &&
                     (state_q == S_IDLE || state_q == S_DONE);
  assign hs   = resp_valid && (state_q == S_WAIT);
  assign diff = resp_data ^ exp_data;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fc_d    = fc_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    ffd_d   = ffd_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          fc_d    = '0;
          ffi_d   = '0;
          ffv_d   = 1'b0;
          ffd_d   = '0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (resp_valid) begin
          if (diff != '0) begin
            // saturate rather than wrap to zero
            fc_d = (&fc_q) ? fc_q : fc_q + FC_ONE;
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = idx_q;
              ffd_d = diff;
            end
          end
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      fc_q    <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
      ffd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fc_q    <= fc_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      ffd_q   <= ffd_d;
    end
  end

  // idx doubles as the registered ROM address
  assign exp_addr         = idx_q;
  assign resp_ready       = (state_q == S_WAIT);
  assign busy             = (state_q == S_FETCH) ||
                            (state_q == S_WAIT);
  assign done             = (state_q == S_DONE);
  assign pass             = done && (fc_q == '0);
  assign fail_count       = fc_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_diff  = ffd_q;

`ifdef RESP_CHECKER_MISR_EN
  logic [OUT_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (start_acc) begin
      sig_d = '0;
    end else if (hs) begin
      sig_d = {sig_q[OUT_W-2:0], 1'b0} ^
              (sig_q[OUT_W-1] ? MISR_POLY[OUT_W-1:0] : '0) ^
              resp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  logic unused_misr;
  assign unused_misr = ^{MISR_POLY, start_acc, hs};
  assign signature   = '0;
`endif

endmodule

// File: doc/atpg_response_checker.md
Name: atpg_response_checker

Overview:
Hardware counterpart of the vector-applying bench: it consumes per-vector DUT responses (e.g. the 32 c1355 outputs) over a valid/ready handshake. Each response is compared against a golden response read from an external synchronous ROM. The block counts mismatches, records the first failing vector, and reports pass/fail. It sits at the response end of the on-chip ATPG pattern path, opposite the stimulus applier.

Parameters:
OUT_W, 32, response width in bits (DUT output count)
NUM_VEC, 10, number of vectors per run (1..2**IDX_W)
IDX_W, 4, vector index / golden ROM address width
MISR_POLY, 32'h04C11DB7, MISR feedback polynomial (low OUT_W bits used; MISR_EN only)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a run; one-cycle pulse; honoured only in IDLE or DONE
resp_valid  input  1  resp_data holds a DUT response
resp_ready  output  1  checker accepts a response this cycle
resp_data  input  OUT_W  DUT response for current vector
exp_addr  output  IDX_W  golden ROM address (registered)
exp_data  input  OUT_W  golden ROM data; valid 1 cycle after exp_addr changes
busy  output  1  run in progress
done  output  1  run complete; held until next start or reset
pass  output  1  done && fail_count==0
fail_count  output  IDX_W+1  number of mismatching vectors this run
first_fail_idx  output  IDX_W  index of first mismatching vector
first_fail_valid  output  1  at least one mismatch recorded
first_fail_diff  output  OUT_W  resp_data ^ exp_data of first mismatch
signature  output  OUT_W  MISR signature (0 when MISR_EN undefined)

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; exp_addr=0; internal idx=0. Reset mid-run abandons the run; no partial done.
- States: IDLE, FETCH, WAIT_RESP, DONE.
- IDLE/DONE + start: clear fail_count, first_fail_*, signature and idx; exp_addr<=0; go FETCH. done drops the cycle after start. start in FETCH/WAIT_RESP is ignored.
- FETCH: one cycle, lets the ROM settle on exp_addr; busy=1; then go WAIT_RESP.
- WAIT_RESP: resp_ready=1. exp_addr is held stable. The handshake completes when resp_valid&&resp_ready. On handshake, mismatch = (resp_data != exp_data).
  - On mismatch: fail_count+1 (saturating at all-ones).
  - On the first mismatch: capture idx and the diff into first_fail_idx / first_fail_diff; set first_fail_valid.
  - If idx==NUM_VEC-1: go DONE. Otherwise idx+1, exp_addr<=idx+1, go FETCH.
- Without a handshake, WAIT_RESP holds indefinitely and no counters change.
- resp_ready=0 in every state other than WAIT_RESP. resp_valid arriving there is not consumed.
- Throughput: 2 cycles per vector minimum. Latency from the last handshake to done=1 is 1 cycle.
- DONE: busy=0, done=1; result registers are frozen.
- NUM_VEC=1: a single FETCH/WAIT_RESP pass, then DONE.

Optional Feature:
RESP_CHECKER_MISR_EN:
- Defined: every accepted response updates signature <= {signature[OUT_W-2:0],1'b0} ^ (signature[OUT_W-1] ? MISR_POLY : 0) ^ resp_data. The seed is 0, cleared on start and on reset. The signature is frozen in DONE.
- Undefined: no MISR logic; the signature port is tied to 0.

Test Plan:
- NUM_VEC=10, all 10 responses equal golden, resp_valid always 1 -> done after 20 cycles from FETCH entry, pass=1, fail_count=0, first_fail_valid=0.
- Golden[3]=0x0000FFFF, response 3 = 0x0001FFFF, others match -> fail_count=1, first_fail_idx=3, first_fail_diff=0x00010000, pass=0.
- Mismatches at vectors 2 and 7 -> fail_count=2, first_fail_idx=2; stall resp_valid low 5 cycles at vector 4 -> no count change, resp_ready stays 1.
- Assert rst during vector 5 of a run, then start -> all outputs 0 after reset; the new run begins at exp_addr=0 with fail_count cleared.
- start pulsed while busy -> ignored; start in DONE -> done falls next cycle and a new run begins.
- MISR_EN defined, NUM_VEC=2, responses 0x80000000 then 0x00000000 -> signature 0x80000000 after the first, 0x04C11DB7 after the second; undefined -> signature=0.
